// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the registered 1:N stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output register slice: loads a beat, drains on ready, no bubble on load+drain.
module stream_demux_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         last_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         last_q, last_d;

    always_comb begin
        valid_d = valid_q & ~ready_i;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1:N stream demux; destination chosen on a packet's first beat and held to its last.
module stream_demux_1ton
    import stream_demux_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned SEL_W = sel_width(N),
    parameter int unsigned CW    = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [W-1:0]   in_data_i,
    input  logic [SEL_W-1:0] in_sel_i,
    input  logic           in_last_i,
    output logic [N-1:0]   out_valid_o,
    input  logic [N-1:0]   out_ready_i,
    output logic [N*W-1:0] out_data_o,
    output logic [N-1:0]   out_last_o,
    output logic           err_sel_o,
    output logic [CW-1:0]  drop_cnt_o
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] dest;
    logic             dest_ok;
    logic             in_ready;
    logic             accept;
    logic [N-1:0]     load;
    logic [N-1:0]     out_valid;
    logic             err_q, err_d;
    logic [CW-1:0]    drop_q, drop_d;

    always_comb begin
        dest = (state_q == ST_LOCKED) ? sel_q : in_sel_i;
        if (N == 1) begin
            dest = '0;
        end
        dest_ok = (32'(dest) < N);

        // An out-of-range destination matches no slot, so its beats are always accepted.
        in_ready = 1'b1;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(dest) == k) begin
                in_ready = ~out_valid[k] | out_ready_i[k];
            end
        end
        accept = in_valid_i & in_ready;

        load = '0;
        for (int unsigned k = 0; k < N; k++) begin
            load[k] = accept && (32'(dest) == k);
        end

        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && !in_last_i) begin
                    state_d = ST_LOCKED;
                    sel_d   = dest;
                end
            end
            ST_LOCKED: begin
                if (accept && in_last_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        err_d  = accept && (state_q == ST_IDLE) && !dest_ok;
        drop_d = drop_q;
        if (accept && in_last_i && !dest_ok && (drop_q != '1)) begin
            drop_d = drop_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_slot
        stream_demux_slot #(
            .W(W)
        ) u_slot (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .load_i (load[g]),
            .data_i (in_data_i),
            .last_i (in_last_i),
            .ready_i(out_ready_i[g]),
            .valid_o(out_valid[g]),
            .data_o (out_data_o[g*W +: W]),
            .last_o (out_last_o[g])
        );
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid;
    assign err_sel_o   = err_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed self-checking bench: N=4 instance for routing/backpressure, N=3 for invalid select.
module tb_stream_demux_1ton;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // N=4 instance
    logic        v4 = 1'b0, l4 = 1'b0, r4;
    logic [1:0]  s4 = '0;
    logic [7:0]  dd4 = '0, dc4;
    logic [3:0]  or4 = '0, ov4, ol4;
    logic [31:0] od4;
    logic        e4;

    // N=3 instance
    logic        v3 = 1'b0, l3 = 1'b0, r3;
    logic [1:0]  s3 = '0;
    logic [7:0]  dd3 = '0, dc3;
    logic [2:0]  or3 = '0, ov3, ol3;
    logic [23:0] od3;
    logic        e3;

    int n_cmp = 0;
    int n_bad = 0;

    stream_demux_1ton #(.N(4), .W(8), .CW(8)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v4), .in_ready_o(r4), .in_data_i(dd4),
        .in_sel_i(s4), .in_last_i(l4), .out_valid_o(ov4), .out_ready_i(or4),
        .out_data_o(od4), .out_last_o(ol4), .err_sel_o(e4), .drop_cnt_o(dc4)
    );

    stream_demux_1ton #(.N(3), .W(8), .CW(8)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v3), .in_ready_o(r3), .in_data_i(dd3),
        .in_sel_i(s3), .in_last_i(l3), .out_valid_o(ov3), .out_ready_i(or3),
        .out_data_o(od3), .out_last_o(ol3), .err_sel_o(e3), .drop_cnt_o(dc3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; v4 = 1'b1; s4 = 2'd1; l4 = 1'b0; dd4 = 8'hEE; or4 = 4'b0000;
        repeat (2) tick();
        n_cmp++; if (ov4 !== 4'b0000) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0000", ov4); end
        n_cmp++; if (dc4 !== 8'h00) begin n_bad++; $display("FAIL reset_drop_cnt: got %h want 00", dc4); end
        n_cmp++; if (e4 !== 1'b0) begin n_bad++; $display("FAIL reset_err_sel: got %b want 0", e4); end
        n_cmp++; if (r4 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", r4); end
        n_cmp++; if (od4 !== 32'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", od4); end
        n_cmp++; if (ov3 !== 3'b000 || dc3 !== 8'h00) begin n_bad++; $display("FAIL reset_n3: got %b/%h want 000/00", ov3, dc3); end
        v4 = 1'b0; rst = 1'b0;
        tick();
    endtask

    task automatic test_single_beat();
        or4 = 4'b1111;
        v4 = 1'b1; s4 = 2'd2; dd4 = 8'hA5; l4 = 1'b1;
        tick();
        v4 = 1'b0;
        n_cmp++; if (ov4 !== 4'b0100) begin n_bad++; $display("FAIL single_valid: got %b want 0100", ov4); end
        n_cmp++; if (od4[23:16] !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", od4[23:16]); end
        n_cmp++; if (ol4[2] !== 1'b1) begin n_bad++; $display("FAIL single_last: got %b want 1", ol4[2]); end
        tick();
        n_cmp++; if (ov4 !== 4'b0000) begin n_bad++; $display("FAIL single_width: got %b want 0000", ov4); end
    endtask

    task automatic test_packet_lock();
        logic [7:0] dat [3];
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
        or4 = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            v4 = 1'b1; s4 = (i == 0) ? 2'd1 : 2'd3; dd4 = dat[i]; l4 = (i == 2);
            tick();
            n_cmp++; if (ov4 !== 4'b0010 || od4[15:8] !== dat[i] || ol4[1] !== (i == 2)) begin
                n_bad++;
                $display("FAIL lock_beat%0d: got v=%b d=%h l=%b want v=0010 d=%h l=%b",
                         i, ov4, od4[15:8], ol4[1], dat[i], (i == 2));
            end
        end
        // FSM back in IDLE: a new single beat follows its own select
        s4 = 2'd3; dd4 = 8'h44; l4 = 1'b1;
        tick();
        v4 = 1'b0;
        n_cmp++; if (ov4 !== 4'b1000 || od4[31:24] !== 8'h44) begin n_bad++; $display("FAIL lock_idle: got %b/%h want 1000/44", ov4, od4[31:24]); end
        tick();
    endtask

    task automatic test_backpressure();
        or4 = 4'b0100;
        v4 = 1'b1; s4 = 2'd0; dd4 = 8'hB1; l4 = 1'b1;
        tick();
        n_cmp++; if (ov4 !== 4'b0001 || od4[7:0] !== 8'hB1) begin n_bad++; $display("FAIL bp_first: got %b/%h want 0001/b1", ov4, od4[7:0]); end
        dd4 = 8'hB2;
        #1;
        n_cmp++; if (r4 !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low: got %b want 0", r4); end
        tick();
        n_cmp++; if (od4[7:0] !== 8'hB1 || ov4[0] !== 1'b1) begin n_bad++; $display("FAIL bp_hold: got %b/%h want 1/b1", ov4[0], od4[7:0]); end
        s4 = 2'd2; dd4 = 8'hC3;
        #1;
        n_cmp++; if (r4 !== 1'b1) begin n_bad++; $display("FAIL bp_other_ready: got %b want 1", r4); end
        tick();
        n_cmp++; if (ov4 !== 4'b0101 || od4[23:16] !== 8'hC3 || od4[7:0] !== 8'hB1) begin
            n_bad++; $display("FAIL bp_other_load: got %b/%h/%h want 0101/c3/b1", ov4, od4[23:16], od4[7:0]);
        end
        s4 = 2'd0; dd4 = 8'hB2; or4 = 4'b0101;
        #1;
        n_cmp++; if (r4 !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", r4); end
        tick();
        v4 = 1'b0;
        n_cmp++; if (ov4 !== 4'b0001 || od4[7:0] !== 8'hB2) begin n_bad++; $display("FAIL bp_no_bubble: got %b/%h want 0001/b2", ov4, od4[7:0]); end
        tick();
        n_cmp++; if (ov4 !== 4'b0000) begin n_bad++; $display("FAIL bp_drain: got %b want 0000", ov4); end
    endtask

    task automatic test_invalid_sel();
        or3 = 3'b111;
        v3 = 1'b1; s3 = 2'd3; dd3 = 8'h01; l3 = 1'b0;
        #1;
        n_cmp++; if (r3 !== 1'b1) begin n_bad++; $display("FAIL inv_ready1: got %b want 1", r3); end
        tick();
        n_cmp++; if (e3 !== 1'b1 || ov3 !== 3'b000) begin n_bad++; $display("FAIL inv_err: got %b/%b want 1/000", e3, ov3); end
        // Locked on the bad select: sel=0 here must still be discarded
        s3 = 2'd0; dd3 = 8'h02; l3 = 1'b1;
        #1;
        n_cmp++; if (r3 !== 1'b1) begin n_bad++; $display("FAIL inv_ready2: got %b want 1", r3); end
        tick();
        n_cmp++; if (e3 !== 1'b0 || ov3 !== 3'b000 || dc3 !== 8'd1) begin
            n_bad++; $display("FAIL inv_drop1: got e=%b v=%b c=%h want 0/000/01", e3, ov3, dc3);
        end
        s3 = 2'd3; l3 = 1'b1;
        for (int i = 0; i < 261; i++) tick();
        v3 = 1'b0;
        tick();
        n_cmp++; if (dc3 !== 8'hFF || ov3 !== 3'b000) begin n_bad++; $display("FAIL inv_saturate: got %h/%b want ff/000", dc3, ov3); end
    endtask

    task automatic test_reset_mid_packet();
        or4 = 4'b0000;
        v4 = 1'b1; s4 = 2'd3; dd4 = 8'h77; l4 = 1'b0;
        tick();
        v4 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (ov4 !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_clear: got %b want 0000", ov4); end
        or4 = 4'b1111;
        v4 = 1'b1; s4 = 2'd0; dd4 = 8'h5A; l4 = 1'b1;
        tick();
        v4 = 1'b0;
        n_cmp++; if (ov4 !== 4'b0001 || od4[7:0] !== 8'h5A) begin n_bad++; $display("FAIL mid_rst_route: got %b/%h want 0001/5a", ov4, od4[7:0]); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_packet_lock();
        test_backpressure();
        test_invalid_sel();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
